// File: rtl/data_mem_pkg.sv
// Shared sizing defaults for the data memory.
// Imported by data_mem so all instances agree on word and address width.
package data_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

endpackage

// File: rtl/data_mem.sv
// Single-port data memory with a registered, read-first output.
// Asynchronous active-low reset clears both the array and the output.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wEn,
  input  logic                  rEn,
  output logic [DATA_WIDTH-1:0] mem_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read samples the pre-write word, so same-address access is read-first
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem_out <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wEn == 1'b1) begin
        mem[addr] <= data;
      end
      if (rEn == 1'b1) begin
        mem_out <= mem[addr];
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed and random checks of data_mem against a reference array.
// Expected outputs are queued at drive time and popped after each edge.
module tb_data_mem;

  logic       clk;
  logic       rstN;
  logic [7:0] data;
  logic [7:0] addr;
  logic       wEn;
  logic       rEn;
  logic [7:0] mem_out;

  logic [7:0] model [256];
  logic [7:0] out_m;
  logic [7:0] sb [$];

  int compared;
  int mismatched;

  data_mem #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk    (clk),
    .rstN   (rstN),
    .data   (data),
    .addr   (addr),
    .wEn    (wEn),
    .rEn    (rEn),
    .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = '0;
    out_m = '0;
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] a,
                      input logic [7:0] d, input string tag);
    @(negedge clk);
    wEn  = w;
    rEn  = r;
    addr = a;
    data = d;
    if (r) out_m = model[a];
    if (w) model[a] = d;
    sb.push_back(out_m);
    @(posedge clk);
    #1;
    check(tag, mem_out, sb.pop_front());
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    wEn  = 1'b1;
    rEn  = 1'b1;
    addr = 8'd0;
    data = 8'hEE;
    #1;
    rstN = 1'b0;
    #1;
    check(tag, mem_out, 8'h00);
    model_clear();
    @(posedge clk);
    #1;
    check({tag, "_held"}, mem_out, 8'h00);
    @(negedge clk);
    wEn  = 1'b0;
    rEn  = 1'b0;
    rstN = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rstN = 1'b0;
    wEn  = 1'b0;
    rEn  = 1'b0;
    addr = '0;
    data = '0;
    model_clear();
    #12;
    check("reset_out", mem_out, 8'h00);
    @(negedge clk);
    rstN = 1'b1;

    step(0, 1, 8'd3,  8'h00, "rd_unwritten_3");
    step(0, 0, 8'd5,  8'h00, "hold_ren0");
    step(0, 1, 8'd25, 8'h00, "rd_unwritten_25");

    step(1, 0, 8'd0, 8'd32, "wr_0");
    step(1, 0, 8'd1, 8'd33, "wr_1");
    step(1, 0, 8'd2, 8'd34, "wr_2");
    step(0, 1, 8'd1, 8'h00, "rd_1");
    step(0, 1, 8'd2, 8'h00, "rd_2");

    step(1, 1, 8'd1, 8'd99, "rw_same_old");
    step(0, 1, 8'd1, 8'h00, "rd_after_rw");

    step(1, 1, 8'd2, 8'd77, "rw_diff_rd2");
    step(1, 1, 8'd3, 8'd44, "rw_diff_rd2_new");

    step(1, 0, 8'd255, 8'hAA, "wr_255");
    step(1, 0, 8'd0,   8'h55, "wr_0b");
    step(0, 1, 8'd255, 8'h00, "rd_255");
    step(0, 1, 8'd0,   8'h00, "rd_0");
    step(0, 0, 8'd255, 8'h00, "hold_55");

    reset_pulse("async_rst");
    step(0, 1, 8'd0,   8'h00, "rd_0_post_rst");
    step(0, 1, 8'd255, 8'h00, "rd_255_post_rst");
    step(1, 0, 8'd4,   8'h3C, "first_wr_post_rst");
    step(0, 1, 8'd4,   8'h00, "rd_4_post_rst");

    for (int k = 0; k < 10; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 7)), 8'($urandom),
           $sformatf("rand_%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
